hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Hazard-detection and pipeline-sequencing controller for the 5-stage pipeline.
- Each cycle it decides whether IF/ID holds, IF/ID is flushed, PC is written and a bubble enters ID/EX.
- Covers three cases: load-use hazards, taken-branch flushes, and a structural hazard on the shared multi-cycle mul/div unit (tracked by an internal busy counter and FSM).
- `ifid_stall` drives the IF/ID register's stall input directly.

Parameters:
- MD_LATENCY, 4: cycles the mul/div unit stays busy after a mul/div leaves ID (legal 1..15).
- CNT_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_muldiv  in  1  ID instruction uses the mul/div unit.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_rd  in  5  ID/EX destination register.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- pc_write  out  1  PC update enable.
- ifid_stall  out  1  hold IF/ID contents.
- ifid_flush  out  1  clear IF/ID to NOP on next edge.
- idex_bubble  out  1  load NOP into ID/EX on next edge.
- md_busy  out  1  md_count != 0.
- ctrl_state  out  1  0=RUN, 1=MD_WAIT.
- stall_cycles  out  CNT_W  optional counter (see Optional Feature).
- flush_cycles  out  CNT_W  optional counter (see Optional Feature).

Behaviour:
- Hazard terms (combinational, every cycle):
  - flush = ex_branch_taken.
  - load_hz = id_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
  - md_hz = id_valid & id_is_muldiv & (md_count != 0).
  - stall = !flush & (load_hz | md_hz).
- Priority: flush > load_hz > md_hz. A flush squashes the ID instruction, so no stall is raised in a flush cycle.
- Outputs (combinational from the hazard terms, outside reset):
  - pc_write = !stall.
  - ifid_stall = stall.
  - ifid_flush = flush.
  - idex_bubble = stall | flush.
- Register $0 never causes a load-use hazard.
- Load-use stall lasts exactly 1 cycle. The inserted bubble clears ex_mem_read on the following cycle, so no extra state is needed.
- md_count (4-bit) behaviour, evaluated each edge:
  - Reset: 0.
  - Load: if id_valid & id_is_muldiv & !stall & !flush, md_count <= MD_LATENCY (issue; the load takes precedence over decrement).
  - Decrement: otherwise, if md_count != 0, md_count <= md_count - 1.
  - Flush does not clear md_count; the in-flight mul/div is older than the branch.
  - Back-to-back mul/div: the second stalls until md_count reaches 0, then issues and reloads MD_LATENCY.
- FSM (ctrl_state):
  - RUN -> MD_WAIT when md_hz & !flush.
  - MD_WAIT -> RUN when md_count == 1 (it will decrement to 0), when flush, or when !md_hz.
  - Otherwise the state holds.
  - ctrl_state is a status output only; the stall decision uses the hazard terms.
- Reset (registered state): md_count=0, ctrl_state=RUN, counters=0.
- Reset (outputs, forced while reset=1): pc_write=0, ifid_stall=0, ifid_flush=0, idex_bubble=1, md_busy=0.
- Reset asserted mid-stall: the stall is abandoned and the next cycle after deassert behaves as RUN with md_count=0.
- Simultaneous flush and load_hz: outputs are pc_write=1, ifid_flush=1, idex_bubble=1, ifid_stall=0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro defined:
  - stall_cycles increments each non-reset cycle with stall=1.
  - flush_cycles increments each non-reset cycle with flush=1.
  - Both are CNT_W wide, saturate at all-ones and clear on reset.
- Without the macro: stall_cycles and flush_cycles are tied to 0 and no counter flops are built.

Test Plan:
- Load-use on rs: ex_mem_read=1, ex_rd=8, id_rs=8, id_valid=1 -> one cycle of pc_write=0, ifid_stall=1, idex_bubble=1; next cycle, with ex_mem_read=0, all-clear (pc_write=1).
- $0 / unused rt: ex_rd=0 matching id_rs=0 -> no stall. ex_rd=9=id_rt with id_uses_rt=0 -> no stall.
- Branch with load hazard: ex_branch_taken=1 in the same cycle as load_hz -> ifid_flush=1, idex_bubble=1, ifid_stall=0, pc_write=1.
- Back-to-back mul/div, MD_LATENCY=4:
  - First mul/div issues -> md_count=4.
  - Second mul/div in ID -> ifid_stall=1 for 4 cycles, ctrl_state=MD_WAIT.
  - Then it issues; md_count reloads 4 and ctrl_state=RUN.
- Reset mid MD_WAIT: reset=1 for 1 cycle -> outputs at reset values; after deassert, md_count=0, ctrl_state=RUN, and a mul/div in ID issues with no stall.
- Perf counters (HAZARD_PERF_CNT_EN defined): 3 stall cycles + 2 flush cycles -> stall_cycles=3, flush_cycles=2. Without the macro, both read 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// and mul/div structural stalls. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_muldiv,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic             ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);
    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [3:0] md_count, md_count_nxt;
    logic       flush, load_hz, md_hz, stall, md_issue;

    always_comb begin
        flush    = ex_branch_taken;
        load_hz  = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                   ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
        md_hz    = id_valid & id_is_muldiv & (md_count != 4'd0);
        // A flush squashes the ID instruction, so it can neither stall nor issue.
        stall    = !flush & (load_hz | md_hz);
        md_issue = id_valid & id_is_muldiv & !stall & !flush;
    end

    always_comb begin
        pc_write    = !stall;
        ifid_stall  = stall;
        ifid_flush  = flush;
        idex_bubble = stall | flush;
        md_busy     = (md_count != 4'd0);
        if (reset) begin
            pc_write    = 1'b0;
            ifid_stall  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            md_busy     = 1'b0;
        end
    end

    // Flush leaves md_count alone: the in-flight mul/div is older than the branch.
    always_comb begin
        md_count_nxt = md_count;
        if (md_issue)
            md_count_nxt = 4'(MD_LATENCY);
        else if (md_count != 4'd0)
            md_count_nxt = md_count - 4'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (md_hz & !flush) state_nxt = MD_WAIT;
            MD_WAIT: if ((md_count == 4'd1) | flush | !md_hz) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_count <= 4'd0;
            state    <= RUN;
        end else begin
            md_count <= md_count_nxt;
            state    <= state_nxt;
        end
    end

    assign ctrl_state = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (flush && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// against a rule-level reference model.
module tb_hazard_stall_ctrl;
    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid, id_uses_rt, id_is_muldiv, ex_mem_read, ex_branch_taken;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             pc_write, ifid_stall, ifid_flush, idex_bubble, md_busy, ctrl_state;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;

    int checks   = 0;
    int failures = 0;

    // Reference state: remaining busy cycles, waiting flag, event tallies.
    int m_cnt = 0;
    bit m_wait = 1'b0;
    int m_sc = 0, m_fc = 0;
    bit e_pc, e_st, e_fl, e_bub, e_busy, e_stall, e_flush;

    hazard_stall_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_muldiv(id_is_muldiv), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .pc_write(pc_write),
        .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .md_busy(md_busy), .ctrl_state(ctrl_state), .stall_cycles(stall_cycles),
        .flush_cycles(flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit v, input int rs, input int rt, input bit urt,
                         input bit md, input bit mr, input int rd, input bit br);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt;
        id_is_muldiv = md; ex_mem_read = mr; ex_rd = 5'(rd); ex_branch_taken = br;
    endtask

    function automatic void model_eval();
        bit lhz, mhz;
        lhz = id_valid && ex_mem_read && ex_rd != 0 &&
              (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        mhz = id_valid && id_is_muldiv && m_cnt > 0;
        e_flush = ex_branch_taken;
        e_stall = !e_flush && (lhz || mhz);
        if (reset) begin
            e_pc = 0; e_st = 0; e_fl = 0; e_bub = 1; e_busy = 0;
        end else begin
            e_pc = !e_stall; e_st = e_stall; e_fl = e_flush;
            e_bub = e_stall || e_flush; e_busy = m_cnt > 0;
        end
    endfunction

    // Advance one clock; the model consumes the inputs that were stable across the edge.
    task automatic tick();
        bit mhz, issue;
        model_eval();
        mhz   = id_valid && id_is_muldiv && m_cnt > 0;
        issue = id_valid && id_is_muldiv && !e_stall && !e_flush;
        @(posedge clk);
        if (reset) begin
            m_cnt = 0; m_wait = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_wait = mhz && !e_flush && (!m_wait || m_cnt != 1);
            m_cnt  = issue ? MD_LATENCY : (m_cnt > 0 ? m_cnt - 1 : 0);
            m_sc += int'(e_stall);
            m_fc += int'(e_flush);
        end
        #1;
    endtask

    function automatic int exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 8, 8, 1, 1, 1, 8, 1);
        #1;
        checks++;
        if ({pc_write, ifid_stall, ifid_flush, idex_bubble, md_busy} !== 5'b00010) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00010",
                     {pc_write, ifid_stall, ifid_flush, idex_bubble, md_busy});
        end
        tick(); tick();
        checks++;
        if (ctrl_state !== 1'b0 || stall_cycles !== '0 || flush_cycles !== '0) begin
            failures++;
            $display("FAIL reset_state got st=%b sc=%0d fc=%0d want 0/0/0",
                     ctrl_state, stall_cycles, flush_cycles);
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_load_use();
        drive(1, 8, 3, 0, 0, 1, 8, 0);
        #1;
        checks++;
        if ({pc_write, ifid_stall, ifid_flush, idex_bubble} !== 4'b0101) begin
            failures++;
            $display("FAIL load_use_rs got=%b want=0101",
                     {pc_write, ifid_stall, ifid_flush, idex_bubble});
        end
        tick();
        ex_mem_read = 1'b0;
        #1;
        checks++;
        if ({pc_write, ifid_stall, ifid_flush, idex_bubble} !== 4'b1000) begin
            failures++;
            $display("FAIL load_use_clear got=%b want=1000",
                     {pc_write, ifid_stall, ifid_flush, idex_bubble});
        end
        tick();
    endtask

    task automatic test_zero_and_rt();
        drive(1, 0, 5, 1, 0, 1, 0, 0);
        #1;
        checks++;
        if (ifid_stall !== 1'b0 || pc_write !== 1'b1) begin
            failures++;
            $display("FAIL reg_zero got stall=%b pc=%b want 0/1", ifid_stall, pc_write);
        end
        tick();
        drive(1, 1, 9, 0, 0, 1, 9, 0);
        #1;
        checks++;
        if (ifid_stall !== 1'b0) begin
            failures++;
            $display("FAIL rt_unused got stall=%b want 0", ifid_stall);
        end
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if (ifid_stall !== 1'b1 || pc_write !== 1'b0) begin
            failures++;
            $display("FAIL rt_used got stall=%b pc=%b want 1/0", ifid_stall, pc_write);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_branch_load();
        drive(1, 8, 0, 0, 0, 1, 8, 1);
        #1;
        checks++;
        if ({pc_write, ifid_stall, ifid_flush, idex_bubble} !== 4'b1011) begin
            failures++;
            $display("FAIL branch_vs_load got=%b want=1011",
                     {pc_write, ifid_stall, ifid_flush, idex_bubble});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 2, 1, 1, 0, 0, 0);
        #1;
        checks++;
        if (ifid_stall !== 1'b0 || md_busy !== 1'b0) begin
            failures++;
            $display("FAIL md_first_issue got stall=%b busy=%b want 0/0", ifid_stall, md_busy);
        end
        tick();
        for (int i = 0; i < MD_LATENCY; i++) begin
            checks++;
            if (ifid_stall !== 1'b1 || pc_write !== 1'b0 || ctrl_state !== (i != 0)) begin
                failures++;
                $display("FAIL md_wait[%0d] got stall=%b pc=%b st=%b want 1/0/%0d",
                         i, ifid_stall, pc_write, ctrl_state, int'(i != 0));
            end
            tick();
        end
        checks++;
        if (ifid_stall !== 1'b0 || ctrl_state !== 1'b0) begin
            failures++;
            $display("FAIL md_second_issue got stall=%b st=%b want 0/0", ifid_stall, ctrl_state);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MD_LATENCY; i++) begin
            #1;
            checks++;
            if (md_busy !== 1'b1) begin
                failures++;
                $display("FAIL md_reload[%0d] got busy=%b want 1", i, md_busy);
            end
            tick();
        end
        checks++;
        if (md_busy !== 1'b0) begin
            failures++;
            $display("FAIL md_drained got busy=%b want 0", md_busy);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive(1, 1, 2, 1, 1, 0, 0, 0);
        tick(); tick(); tick();
        checks++;
        if (ctrl_state !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got st=%b want 1", ctrl_state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_stall, ifid_flush, idex_bubble, md_busy} !== 5'b00010) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%b want=00010",
                     {pc_write, ifid_stall, ifid_flush, idex_bubble, md_busy});
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (ctrl_state !== 1'b0 || md_busy !== 1'b0 || ifid_stall !== 1'b0 || pc_write !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_after got st=%b busy=%b stall=%b pc=%b want 0/0/0/1",
                     ctrl_state, md_busy, ifid_stall, pc_write);
        end
        tick();
        checks++;
        if (md_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_issue got busy=%b want 1", md_busy);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MD_LATENCY; i++) tick();
    endtask

    task automatic test_perf();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 7, 0, 0, 0, 1, 7, 0);
        tick(); tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall_cycles !== CNT_W'(exp_cnt(3)) || flush_cycles !== CNT_W'(exp_cnt(2))) begin
            failures++;
            $display("FAIL perf_counts got sc=%0d fc=%0d want %0d/%0d",
                     stall_cycles, flush_cycles, exp_cnt(3), exp_cnt(2));
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 9) == 0);
            #1;
            model_eval();
            checks++;
            if ({pc_write, ifid_stall, ifid_flush, idex_bubble, md_busy, ctrl_state} !==
                {e_pc, e_st, e_fl, e_bub, e_busy, m_wait} ||
                stall_cycles !== CNT_W'(exp_cnt(m_sc)) || flush_cycles !== CNT_W'(exp_cnt(m_fc))) begin
                failures++;
                $display("FAIL random[%0d] got=%b sc=%0d fc=%0d want=%b sc=%0d fc=%0d", n,
                         {pc_write, ifid_stall, ifid_flush, idex_bubble, md_busy, ctrl_state},
                         stall_cycles, flush_cycles,
                         {e_pc, e_st, e_fl, e_bub, e_busy, m_wait}, exp_cnt(m_sc), exp_cnt(m_fc));
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_and_rt();
        test_branch_load();
        test_back_to_back();
        test_reset_mid_wait();
        test_perf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
